// File: rtl/dbus_burst_master.sv
// dbus_burst_master
// Avalon-MM style burst initiator used as a bring-up traffic generator and
// self-check in front of the SDRAM controller dbus port. It writes a burst of
// the pattern seed+i, then reads the burst back and counts mismatching beats.
//
// Optional feature macro: DBUS_BURST_MASTER_TIMEOUT_EN
//   When defined, a watchdog aborts a stalled transaction after TIMEOUT cycles
//   without progress. It sets o_timeout and ends with a done pulse.
//   When undefined, no watchdog is built and o_timeout stays 0.
//
// Ports
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_start               : run request, sampled only while idle
//   i_cfg_mode            : 00 write, 01 read+check, 10/11 write then read+check
//   i_cfg_address         : burst byte address (bit 0 forced to 0 on the bus)
//   i_cfg_burstcount      : beats per burst (0 -> 1, clamped to MAX_BURST)
//   i_cfg_seed            : data pattern seed
//   o_busy, o_done        : transaction in progress / one-cycle end pulse
//   o_error, o_err_count  : sticky mismatch flag / saturating mismatch count
//   o_timeout             : watchdog abort flag
//   o_dbus_*              : Avalon-MM master command/data outputs
//   i_dbus_*              : Avalon-MM slave responses
module dbus_burst_master #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_cfg_mode,
  input  logic [ADDR_W-1:0] i_cfg_address,
  input  logic [6:0]        i_cfg_burstcount,
  input  logic [DATA_W-1:0] i_cfg_seed,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [7:0]        o_err_count,
  output logic              o_timeout,
  output logic [ADDR_W-1:0] o_dbus_address,
  output logic [DATA_W-1:0] o_dbus_writedata,
  output logic [1:0]        o_dbus_byteenable,
  output logic [6:0]        o_dbus_burstcount,
  output logic              o_dbus_read,
  output logic              o_dbus_write,
  input  logic              i_dbus_waitrequest,
  input  logic [DATA_W-1:0] i_dbus_readdata,
  input  logic              i_dbus_readdatavalid
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_CMD  = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [6:0] MAX_BC = 7'(MAX_BURST);

  state_t            r_state,  w_state_nxt;
  logic [6:0]        r_beat,   w_beat_nxt;
  logic [6:0]        r_len,    w_len_nxt;
  logic [DATA_W-1:0] r_seed,   w_seed_nxt;
  logic              r_rd_after, w_rd_after_nxt;
  logic              r_error,  w_error_nxt;
  logic [7:0]        r_err_count, w_err_count_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic              r_busy,   r_done, r_dbus_read, r_dbus_write;
  logic [ADDR_W-1:0] r_dbus_address, w_addr_nxt;
  logic [DATA_W-1:0] r_dbus_writedata, w_wdata_nxt;
  logic [1:0]        r_dbus_byteenable;
  logic [6:0]        r_dbus_burstcount, w_bc_nxt;
  logic [6:0]        w_len_cfg;
  logic [DATA_W-1:0] w_expect;
  logic              w_match;
  logic              w_check;
  logic              w_last_beat;

  // Effective burst length from the configuration: 0 means 1, large values clamp.
  always_comb begin
    w_len_cfg = i_cfg_burstcount;
    if (i_cfg_burstcount == 7'd0) begin
      w_len_cfg = 7'd1;
    end else if (i_cfg_burstcount > MAX_BC) begin
      w_len_cfg = MAX_BC;
    end else begin
      w_len_cfg = i_cfg_burstcount;
    end
  end

  assign w_expect    = r_seed + DATA_W'(r_beat);
  assign w_match     = (i_dbus_readdata == w_expect);
  assign w_last_beat = (r_beat == (r_len - 7'd1));

`ifdef DBUS_BURST_MASTER_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT + 1);
  logic [WDOG_W-1:0] r_wdog, w_wdog_nxt;
  logic              w_progress;
  logic              w_expire;

  // Any forward step of the transaction re-arms the watchdog.
  assign w_progress = (r_state == ST_IDLE    && i_start) ||
                      (r_state == ST_WR      && !i_dbus_waitrequest) ||
                      (r_state == ST_RD_CMD  && (!i_dbus_waitrequest || i_dbus_readdatavalid)) ||
                      (r_state == ST_RD_DATA && i_dbus_readdatavalid);

  // The counter holds the number of cycles elapsed since the last progress
  // event, so expiring at TIMEOUT-1 places the done pulse TIMEOUT cycles later.
  assign w_expire = (r_state == ST_WR || r_state == ST_RD_CMD || r_state == ST_RD_DATA) &&
                    !w_progress && (r_wdog == WDOG_W'(TIMEOUT - 1));

  // Watchdog next value: restart on progress, count while busy, rest at zero.
  always_comb begin
    w_wdog_nxt = r_wdog;
    if (w_progress) begin
      w_wdog_nxt = {{(WDOG_W-1){1'b0}}, 1'b1};
    end else if (r_state == ST_WR || r_state == ST_RD_CMD || r_state == ST_RD_DATA) begin
      w_wdog_nxt = r_wdog + {{(WDOG_W-1){1'b0}}, 1'b1};
    end else begin
      w_wdog_nxt = {WDOG_W{1'b0}};
    end
  end

  // Watchdog counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wdog <= {WDOG_W{1'b0}};
    end else begin
      r_wdog <= w_wdog_nxt;
    end
  end
`endif

  // Next-state, latched configuration and check logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat;
    w_len_nxt       = r_len;
    w_seed_nxt      = r_seed;
    w_rd_after_nxt  = r_rd_after;
    w_addr_nxt      = r_dbus_address;
    w_bc_nxt        = r_dbus_burstcount;
    w_error_nxt     = r_error;
    w_err_count_nxt = r_err_count;
    w_timeout_nxt   = r_timeout;
    w_check         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_len_nxt       = w_len_cfg;
          w_bc_nxt        = w_len_cfg;
          w_seed_nxt      = i_cfg_seed;
          w_addr_nxt      = i_cfg_address & ~{{(ADDR_W-1){1'b0}}, 1'b1};
          w_rd_after_nxt  = i_cfg_mode[1];
          w_beat_nxt      = 7'd0;
          w_error_nxt     = 1'b0;
          w_err_count_nxt = 8'd0;
          w_timeout_nxt   = 1'b0;
          w_state_nxt     = (i_cfg_mode == 2'b01) ? ST_RD_CMD : ST_WR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WR: begin
        if (!i_dbus_waitrequest) begin
          if (w_last_beat) begin
            w_beat_nxt  = 7'd0;
            w_state_nxt = r_rd_after ? ST_RD_CMD : ST_DONE;
          end else begin
            w_beat_nxt = r_beat + 7'd1;
          end
        end else begin
          w_beat_nxt = r_beat;
        end
      end
      ST_RD_CMD: begin
        if (!i_dbus_waitrequest) begin
          // A beat returned in the acceptance cycle is beat 0 and is checked now.
          if (i_dbus_readdatavalid) begin
            w_check = 1'b1;
            if (w_last_beat) begin
              w_beat_nxt  = 7'd0;
              w_state_nxt = ST_DONE;
            end else begin
              w_beat_nxt  = 7'd1;
              w_state_nxt = ST_RD_DATA;
            end
          end else begin
            w_beat_nxt  = 7'd0;
            w_state_nxt = ST_RD_DATA;
          end
        end else begin
          w_state_nxt = ST_RD_CMD;
        end
      end
      ST_RD_DATA: begin
        if (i_dbus_readdatavalid) begin
          w_check = 1'b1;
          if (w_last_beat) begin
            w_beat_nxt  = 7'd0;
            w_state_nxt = ST_DONE;
          end else begin
            w_beat_nxt = r_beat + 7'd1;
          end
        end else begin
          w_state_nxt = ST_RD_DATA;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_check && !w_match) begin
      w_error_nxt = 1'b1;
      if (r_err_count != 8'hFF) begin
        w_err_count_nxt = r_err_count + 8'd1;
      end else begin
        w_err_count_nxt = r_err_count;
      end
    end else begin
      w_error_nxt = w_error_nxt;
    end

`ifdef DBUS_BURST_MASTER_TIMEOUT_EN
    if (w_expire) begin
      w_state_nxt   = ST_DONE;
      w_beat_nxt    = 7'd0;
      w_timeout_nxt = 1'b1;
    end else begin
      w_timeout_nxt = w_timeout_nxt;
    end
`endif

    // Write data follows the beat that will be presented next cycle.
    if (w_state_nxt == ST_WR) begin
      w_wdata_nxt = w_seed_nxt + DATA_W'(w_beat_nxt);
    end else begin
      w_wdata_nxt = {DATA_W{1'b0}};
    end
  end

  // State, datapath and registered outputs. Bus strobes are decoded from the
  // next state so they line up with the state they belong to.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state           <= ST_IDLE;
      r_beat            <= 7'd0;
      r_len             <= 7'd0;
      r_seed            <= {DATA_W{1'b0}};
      r_rd_after        <= 1'b0;
      r_error           <= 1'b0;
      r_err_count       <= 8'd0;
      r_timeout         <= 1'b0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_dbus_read       <= 1'b0;
      r_dbus_write      <= 1'b0;
      r_dbus_address    <= {ADDR_W{1'b0}};
      r_dbus_writedata  <= {DATA_W{1'b0}};
      r_dbus_byteenable <= 2'b00;
      r_dbus_burstcount <= 7'd0;
    end else begin
      r_state           <= w_state_nxt;
      r_beat            <= w_beat_nxt;
      r_len             <= w_len_nxt;
      r_seed            <= w_seed_nxt;
      r_rd_after        <= w_rd_after_nxt;
      r_error           <= w_error_nxt;
      r_err_count       <= w_err_count_nxt;
      r_timeout         <= w_timeout_nxt;
      r_busy            <= (w_state_nxt == ST_WR) || (w_state_nxt == ST_RD_CMD) ||
                           (w_state_nxt == ST_RD_DATA);
      r_done            <= (w_state_nxt == ST_DONE);
      r_dbus_read       <= (w_state_nxt == ST_RD_CMD);
      r_dbus_write      <= (w_state_nxt == ST_WR);
      r_dbus_address    <= w_addr_nxt;
      r_dbus_writedata  <= w_wdata_nxt;
      r_dbus_byteenable <= ((w_state_nxt == ST_WR) || (w_state_nxt == ST_RD_CMD)) ? 2'b11 : 2'b00;
      r_dbus_burstcount <= w_bc_nxt;
    end
  end

  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_error           = r_error;
  assign o_err_count       = r_err_count;
  assign o_timeout         = r_timeout;
  assign o_dbus_address    = r_dbus_address;
  assign o_dbus_writedata  = r_dbus_writedata;
  assign o_dbus_byteenable = r_dbus_byteenable;
  assign o_dbus_burstcount = r_dbus_burstcount;
  assign o_dbus_read       = r_dbus_read;
  assign o_dbus_write      = r_dbus_write;

endmodule

// File: tb/tb_dbus_burst_master.sv
// Self-checking bench for dbus_burst_master: directed cases plus randomized
// transactions against a pattern/length/error-count reference model.
module tb_dbus_burst_master;

  localparam int AW = 25;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    cfg_mode;
  logic [AW-1:0] cfg_address;
  logic [6:0]    cfg_burstcount;
  logic [DW-1:0] cfg_seed;
  logic          busy, done, error, timeout_o;
  logic [7:0]    err_count;
  logic [AW-1:0] dbus_address;
  logic [DW-1:0] dbus_writedata;
  logic [1:0]    dbus_byteenable;
  logic [6:0]    dbus_burstcount;
  logic          dbus_read, dbus_write;
  logic          dbus_waitrequest;
  logic [DW-1:0] dbus_readdata;
  logic          dbus_readdatavalid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dbus_burst_master #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16), .TIMEOUT(1023)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_cfg_mode(cfg_mode),
    .i_cfg_address(cfg_address), .i_cfg_burstcount(cfg_burstcount), .i_cfg_seed(cfg_seed),
    .o_busy(busy), .o_done(done), .o_error(error), .o_err_count(err_count),
    .o_timeout(timeout_o), .o_dbus_address(dbus_address), .o_dbus_writedata(dbus_writedata),
    .o_dbus_byteenable(dbus_byteenable), .o_dbus_burstcount(dbus_burstcount),
    .o_dbus_read(dbus_read), .o_dbus_write(dbus_write),
    .i_dbus_waitrequest(dbus_waitrequest), .i_dbus_readdata(dbus_readdata),
    .i_dbus_readdatavalid(dbus_readdatavalid)
  );

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input int bc);
    if (bc == 0) return 1;
    if (bc > 16) return 16;
    return bc;
  endfunction

  // One complete transaction; the bench acts as the slave. Called and returning
  // at 1 time unit after a rising edge with the DUT idle.
  task automatic run_txn(input logic [1:0] mode, input logic [AW-1:0] addr,
                         input logic [6:0] bc, input logic [DW-1:0] seed,
                         input int wait_pct, input int forced_waits,
                         input logic [15:0] corrupt, input int valid_pct,
                         input bit scramble, output int done_c);
    int n, exp_err, wr_idx, rd_idx, rd_left, cmd_cnt, last_evt, forced;
    bit do_wr, do_rd, w, seen_done, prev_wr, prev_wait, exp_error;
    logic [DW-1:0] exp_data[$];
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr, exp_addr;
    n = eff_len(int'(bc));
    do_wr = (mode != 2'b01);
    do_rd = (mode != 2'b00);
    exp_addr = addr & ~25'd1;
    exp_err = 0;
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(seed + DW'(i));
      if (do_rd && corrupt[i]) exp_err++;
    end
    exp_error = (exp_err > 0);
    wr_idx = 0; rd_idx = 0; rd_left = 0; cmd_cnt = 0; last_evt = -1;
    forced = forced_waits; seen_done = 1'b0; prev_wr = 1'b0; prev_wait = 1'b0;
    prev_data = '0; prev_addr = '0; done_c = -1;

    cfg_mode = mode; cfg_address = addr; cfg_burstcount = bc; cfg_seed = seed;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_val("busy_after_start", 32'(busy), 32'd1);
    chk_val("error_cleared", 32'(error), 32'd0);
    chk_val("errcnt_cleared", 32'(err_count), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      if (done) begin
        seen_done = 1'b1;
        done_c = c;
        break;
      end
      w = ($urandom_range(99) < wait_pct);
      if (forced > 0 && (dbus_write || dbus_read)) begin
        w = 1'b1;
        forced--;
      end
      if (prev_wr && prev_wait) begin
        chk_val("stall_wr_held", 32'(dbus_write), 32'd1);
        chk_val("stall_data_held", 32'(dbus_writedata), 32'(prev_data));
        chk_val("stall_addr_held", 32'(dbus_address), 32'(prev_addr));
      end
      if (dbus_write || dbus_read) begin
        chk_val("cmd_burstcount", 32'(dbus_burstcount), 32'(n));
        chk_val("cmd_address", 32'(dbus_address), 32'(exp_addr));
        chk_val("cmd_byteenable", 32'(dbus_byteenable), 32'd3);
      end else begin
        chk_val("idle_byteenable", 32'(dbus_byteenable), 32'd0);
      end
      if (dbus_write && !w) begin
        chk_val("wr_beat_in_range", 32'(wr_idx < n), 32'd1);
        if (wr_idx < n) chk_val("wr_data", 32'(dbus_writedata), 32'(exp_data[wr_idx]));
        wr_idx++;
        last_evt = c;
      end
      if (dbus_read) begin
        chk_val("wr_before_rd", 32'(wr_idx), do_wr ? 32'(n) : 32'd0);
        if (!w) begin
          cmd_cnt++;
          rd_left = n;
          rd_idx = 0;
        end
      end
      dbus_readdatavalid = 1'b0;
      dbus_readdata = DW'($urandom);
      if (rd_left > 0 && $urandom_range(99) < valid_pct) begin
        dbus_readdatavalid = 1'b1;
        dbus_readdata = exp_data[rd_idx] ^ (corrupt[rd_idx] ? 16'h5A01 : 16'h0000);
        rd_idx++;
        rd_left--;
        last_evt = c;
      end else if (dbus_write && $urandom_range(3) == 0) begin
        dbus_readdatavalid = 1'b1;
      end
      dbus_waitrequest = w;
      if (scramble) begin
        start = ($urandom_range(7) == 0);
        cfg_mode = 2'($urandom);
        cfg_address = AW'($urandom);
        cfg_burstcount = 7'($urandom);
        cfg_seed = DW'($urandom);
      end
      prev_wr = dbus_write; prev_wait = w;
      prev_data = dbus_writedata; prev_addr = dbus_address;
      @(posedge clk); #1;
    end
    start = 1'b0;
    dbus_waitrequest = 1'b0;
    dbus_readdatavalid = 1'b0;
    chk_val("done_seen", 32'(seen_done), 32'd1);
    chk_val("done_latency", 32'(done_c), 32'(last_evt + 1));
    chk_val("done_busy_low", 32'(busy), 32'd0);
    chk_val("done_error", 32'(error), 32'(exp_error));
    chk_val("done_errcnt", 32'(err_count), 32'(exp_err));
    chk_val("done_timeout", 32'(timeout_o), 32'd0);
    chk_val("wr_beats", 32'(wr_idx), do_wr ? 32'(n) : 32'd0);
    chk_val("rd_cmds", 32'(cmd_cnt), do_rd ? 32'd1 : 32'd0);
    chk_val("rd_beats", 32'(rd_idx), do_rd ? 32'(n) : 32'd0);
    @(posedge clk); #1;
    chk_val("done_one_cycle", 32'(done), 32'd0);
    chk_val("post_busy", 32'(busy), 32'd0);
    chk_val("post_cmd_low", 32'({dbus_read, dbus_write}), 32'd0);
    chk_val("error_held", 32'(error), 32'(exp_error));
    chk_val("errcnt_held", 32'(err_count), 32'(exp_err));
  endtask

  initial begin
    int dc;
    logic [1:0] m;
    rst = 1'b1; start = 1'b0; cfg_mode = 2'b00; cfg_address = '0;
    cfg_burstcount = 7'd0; cfg_seed = '0; dbus_waitrequest = 1'b0;
    dbus_readdata = '0; dbus_readdatavalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_busy", 32'(busy), 32'd0);
    chk_val("rst_done", 32'(done), 32'd0);
    chk_val("rst_error", 32'(error), 32'd0);
    chk_val("rst_errcnt", 32'(err_count), 32'd0);
    chk_val("rst_cmds", 32'({dbus_read, dbus_write}), 32'd0);
    chk_val("rst_addr", 32'(dbus_address), 32'd0);
    chk_val("rst_wdata", 32'(dbus_writedata), 32'd0);
    chk_val("rst_be", 32'(dbus_byteenable), 32'd0);
    chk_val("rst_bc", 32'(dbus_burstcount), 32'd0);
    chk_val("rst_timeout", 32'(timeout_o), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write then read, zero wait: 8 writes, command with beat 0, 8 reads.
    run_txn(2'b10, 25'h0000018, 7'd8, 16'h4440, 0, 0, 16'h0000, 100, 1'b0, dc);
    chk_val("t1_done_cycle", 32'(dc), 32'd16);
    // Single write held off by 5 wait cycles.
    run_txn(2'b00, 25'h0000123, 7'd1, 16'hFFFF, 0, 5, 16'h0000, 100, 1'b0, dc);
    chk_val("t2_done_cycle", 32'(dc), 32'd6);
    // Read-check of 16 beats with beats 3 and 9 corrupted.
    run_txn(2'b01, 25'h0100000, 7'd16, 16'h0000, 0, 0, 16'h0208, 100, 1'b0, dc);
    chk_val("t3_done_cycle", 32'(dc), 32'd16);
    // Burst length boundaries, mode 11 behaves as 10.
    run_txn(2'b11, 25'h0000040, 7'd0, 16'h1234, 20, 0, 16'h0001, 70, 1'b0, dc);
    run_txn(2'b10, 25'h0000080, 7'd100, 16'hFFF8, 20, 0, 16'h8000, 70, 1'b0, dc);

    // Reset during the 4th of 8 write beats.
    cfg_mode = 2'b00; cfg_address = 25'h0000200; cfg_burstcount = 7'd8; cfg_seed = 16'hABCD;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk_val("rst_mid_wr_active", 32'(dbus_write), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_val("rst_mid_wr_low", 32'(dbus_write), 32'd0);
    chk_val("rst_mid_busy", 32'(busy), 32'd0);
    chk_val("rst_mid_done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk_val("rst_mid_no_done", 32'(done), 32'd0);
    end
    run_txn(2'b10, 25'h0000200, 7'd8, 16'hABCD, 10, 0, 16'h0000, 80, 1'b0, dc);

    // Randomized transactions with stalls, gaps, corruption and ignored starts.
    for (int t = 0; t < 25; t++) begin
      m = 2'($urandom);
      run_txn(m, AW'($urandom), ($urandom_range(3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 17)),
              DW'($urandom), $urandom_range(0, 60), 0, 16'($urandom),
              $urandom_range(30, 100), 1'b1, dc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_burst_master.md
Name: dbus_burst_master

Overview:
- Synthesizable Avalon-MM style burst initiator for the SDRAM controller's dbus port.
- Generates write bursts with a deterministic data pattern, then issues read bursts and checks the returned data against the same pattern.
- Sits in front of sdram_controller as an on-chip traffic generator and self-check for bring-up.
- Also usable as an arbitration test client.

Parameters:
- ADDR_W, 25: dbus byte-address width.
- DATA_W, 16: dbus data width.
- MAX_BURST, 16: largest burst issued; larger requests are clamped to this value.
- TIMEOUT, 1023: watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run a transaction; sampled only in IDLE
- cfg_mode  in  2  00 write only, 01 read+check only, 10 write then read+check, 11 treated as 10
- cfg_address  in  ADDR_W  burst start byte address; bit 0 is forced to 0 on dbus_address
- cfg_burstcount  in  7  beats per burst; 0 is treated as 1; values above MAX_BURST are clamped to MAX_BURST
- cfg_seed  in  DATA_W  pattern seed
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at transaction end
- error  out  1  sticky mismatch flag; cleared by accepted start or rst
- err_count  out  8  mismatching beats, saturates at 255; cleared by accepted start
- timeout  out  1  watchdog abort flag (see Optional Feature)
- dbus_address  out  ADDR_W  burst address
- dbus_writedata  out  DATA_W  write data
- dbus_byteenable  out  2  always 2'b11 while write or read is high, else 2'b00
- dbus_burstcount  out  7  effective burst length
- dbus_read  out  1  read command
- dbus_write  out  1  write command/data strobe
- dbus_waitrequest  in  1  slave stall
- dbus_readdata  in  DATA_W  read data
- dbus_readdatavalid  in  1  read beat valid

Behaviour:
- Reset values: all outputs 0; state IDLE; beat counter 0.
- Effective burst length N is computed and latched from cfg_burstcount at start. cfg_address and cfg_seed are latched at the same time.
- Pattern: beat i data = seed + i, modulo 2^DATA_W, with i = 0..N-1.
- IDLE:
  - start=1 latches the config, clears error/err_count/timeout and sets busy the next cycle.
  - The next state is WR for mode 00/10, or RD_CMD for mode 01.
- WR:
  - dbus_write=1, with address and burstcount held constant for the whole burst.
  - dbus_writedata = pattern beat i.
  - A beat is accepted on a cycle with dbus_waitrequest=0; the counter then increments.
  - When beat N-1 is accepted, the next state is DONE (mode 00) or RD_CMD (mode 10), and dbus_write drops the next cycle.
  - Under waitrequest, all dbus outputs stay stable.
- RD_CMD:
  - dbus_read=1 with address and burstcount.
  - The command is accepted on the first cycle with waitrequest=0; dbus_read drops the next cycle.
  - The beat counter is reset and the next state is RD_DATA.
  - If dbus_readdatavalid is asserted in the same cycle the command is accepted, that beat is captured.
- RD_DATA:
  - Each cycle with dbus_readdatavalid=1 compares dbus_readdata with pattern beat i.
  - On mismatch: error=1 and err_count+1 (saturating).
  - After beat N-1 is received, the next state is DONE.
- readdatavalid in any state other than RD_CMD/RD_DATA is ignored.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE. error and err_count hold their values.
- start while busy is ignored; no queuing.
- Burst address increments are the slave's responsibility: dbus_address is not advanced per beat.
- rst mid-burst: dbus_read and dbus_write are 0 in the cycle after rst, the state returns to IDLE, and no done pulse is generated.

Optional Feature:
- Macro: DBUS_BURST_MASTER_TIMEOUT_EN.
- When defined:
  - A watchdog counter is reset on start, on every accepted write beat, on command acceptance and on every readdatavalid.
  - If the counter reaches TIMEOUT while busy, the block sets timeout=1, drops dbus_read/dbus_write, pulses done and returns to IDLE.
- When undefined: no watchdog is built, timeout is tied to 0, and the block waits indefinitely.

Test Plan:
- Mode 10, address 0x0000018, N=8, seed 0x4440, zero-wait responder -> 8 write beats 0x4440..0x4447 on consecutive cycles; one read command with burstcount 8; 8 matching beats; done pulse; error=0; err_count=0.
- Mode 00, N=1, seed 0xFFFF, waitrequest held high 5 cycles -> write, address and data stable for 5 cycles; accepted on the 6th; done the next cycle.
- Mode 01, N=16, seed 0x0000, responder corrupts beats 3 and 9 -> error=1, err_count=2, done after the 16th readdatavalid.
- cfg_burstcount=0 then 100 -> dbus_burstcount=1, then 16; beat counts match.
- rst asserted during the 4th write beat of 8 -> dbus_write=0 the next cycle, busy=0, no done; a subsequent start runs normally.
- With DBUS_BURST_MASTER_TIMEOUT_EN and TIMEOUT=31, the responder never asserts readdatavalid -> timeout=1 and a done pulse 31 cycles after command acceptance; without the macro, busy stays high.
